// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg
//   Shared definitions for the RV32M multiply/divide unit. The decoder and
//   the hazard unit use the same constants.
//   - func3 op codes for the eight M-extension operations
//   - 2-bit FSM state encoding
//   - M-extension func7 constant
package ex_muldiv_unit_pkg;

    localparam logic [6:0] MEXT_FUNC7 = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if
//   Groups the ID/EX-side request and the EX/MEM-side response of the
//   multiply/divide unit.
//   master : pipeline side (drives i_*, observes o_*)
//   slave  : the unit itself (observes i_*, drives o_*)
interface ex_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_start;
    logic                  i_flush;
    logic [2:0]            i_func3;
    logic [DATA_WIDTH-1:0] i_rs1_data;
    logic [DATA_WIDTH-1:0] i_rs2_data;
    logic [4:0]            i_rd_addr;
    logic                  o_busy;
    logic                  o_done;
    logic [DATA_WIDTH-1:0] o_result;
    logic [4:0]            o_rd_addr;

    modport master (
        output i_start, i_flush, i_func3, i_rs1_data, i_rs2_data, i_rd_addr,
        input  o_busy, o_done, o_result, o_rd_addr
    );

    modport slave (
        input  i_start, i_flush, i_func3, i_rs1_data, i_rs2_data, i_rd_addr,
        output o_busy, o_done, o_result, o_rd_addr
    );
endinterface

// File: rtl/ex_muldiv_step.sv
// ex_muldiv_step
//   One combinational iteration of the multiply/divide datapath.
//   acc_i  : 2*DATA_WIDTH accumulator {upper, lower}
//   opnd_i : multiplicand (multiply) or divisor (divide), magnitude
//   div_i  : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_o  : accumulator after this iteration
module ex_muldiv_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH-1:0] acc_i,
    input  logic [DATA_WIDTH-1:0]   opnd_i,
    input  logic                    div_i,
    output logic [2*DATA_WIDTH-1:0] acc_o
);
    localparam int W = DATA_WIDTH;

    logic [W:0] upper_sum;
    logic [W:0] trial;

    // Multiply: the lower half holds the remaining multiplier bits; add the
    // multiplicand into the upper half when the LSB is set, then shift right
    // keeping the carry.
    assign upper_sum = {1'b0, acc_i[2*W-1:W]} + {1'b0, opnd_i};

    // Divide: the upper half is the partial remainder; shift in the next
    // dividend bit and try subtracting the divisor (W+1 bits so the borrow
    // shows in the MSB).
    assign trial = acc_i[2*W-1:W-1] - {1'b0, opnd_i};

    always_comb begin
        acc_o = acc_i;
        if (div_i) begin
            if (trial[W])
                acc_o = {acc_i[2*W-2:0], 1'b0};
            else
                acc_o = {trial[W-1:0], acc_i[W-2:0], 1'b1};
        end else begin
            if (acc_i[0])
                acc_o = {upper_sum, acc_i[W-1:1]};
            else
                acc_o = {1'b0, acc_i[2*W-1:1]};
        end
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative RV32M multiply/divide unit for the EX stage. Holds the FSM,
//   iteration counter, operand latches, special-case detection and sign fix.
//   Ports:
//     clk   : clock, rising edge
//     i_rst : asynchronous active-high reset
//     bus   : ex_muldiv_unit_if.slave (start/flush/func3/operands/rd in,
//             busy/done/result/rd out)
//   Optional feature: define MULDIV_FAST_MUL_EN to compute all multiplies
//   with a single-cycle registered product (IDLE -> DONE).
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NB_CNT     = 6
) (
    input  logic              clk,
    input  logic              i_rst,
    ex_muldiv_unit_if.slave   bus
);
    localparam int W = DATA_WIDTH;

    state_t                state_q, state_d;
    logic [NB_CNT-1:0]     cnt_q;
    logic [2*W-1:0]        acc_q;
    logic [2*W-1:0]        acc_step;
    logic [W-1:0]          opnd_q;
    logic [2:0]            func3_q;
    logic                  neg_q;
    logic [4:0]            rd_lat_q;
    logic [W-1:0]          result_q;
    logic [4:0]            rd_out_q;
    logic                  done_q;

    // Incoming-op decode
    logic [2:0]   f3;
    logic         is_div, a_sgn, b_sgn, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic         div_zero, div_ovf, special, is_fast, idle_or_done, accept, busy;
    logic [W-1:0] special_res;
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix, rem_fix, fix_res;

    assign f3     = bus.i_func3;
    assign is_div = f3[2];
    // DIV/REM have func3[0]=0 and are signed on both sides.
    assign a_sgn  = is_div ? ~f3[0] : (f3 == F3_MULH || f3 == F3_MULHSU);
    assign b_sgn  = is_div ? ~f3[0] : (f3 == F3_MULH);
    assign a_neg  = a_sgn & bus.i_rs1_data[W-1];
    assign b_neg  = b_sgn & bus.i_rs2_data[W-1];
    assign a_mag  = a_neg ? -bus.i_rs1_data : bus.i_rs1_data;
    assign b_mag  = b_neg ? -bus.i_rs2_data : bus.i_rs2_data;

    assign div_zero = is_div && (bus.i_rs2_data == '0);
    assign div_ovf  = is_div && !f3[0] &&
                      (bus.i_rs1_data == {1'b1, {(W-1){1'b0}}}) &&
                      (bus.i_rs2_data == {W{1'b1}});
    assign special  = div_zero | div_ovf;
    // REM variants (func3[1]=1) return the dividend / zero; DIV variants
    // return all ones / the most negative value.
    assign special_res = div_zero ? (f3[1] ? bus.i_rs1_data : {W{1'b1}})
                                  : (f3[1] ? '0 : bus.i_rs1_data);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [W:0]     fast_a, fast_b;
    logic signed [2*W+1:0] fast_prod;
    logic [W-1:0]          fast_res;
    assign fast_a    = {a_neg, bus.i_rs1_data};
    assign fast_b    = {b_neg, bus.i_rs2_data};
    assign fast_prod = fast_a * fast_b;
    assign fast_res  = (f3 == F3_MUL) ? fast_prod[W-1:0] : fast_prod[2*W-1:W];
    assign is_fast   = ~is_div;
`else
    assign is_fast   = 1'b0;
`endif

    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept       = bus.i_start && !bus.i_flush && idle_or_done;

    ex_muldiv_step #(.DATA_WIDTH(W)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .div_i  (func3_q[2]),
        .acc_o  (acc_step)
    );

    // Sign fix applied in the FIX state.
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix  = neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
        case (func3_q)
            F3_MUL:                       fix_res = prod_fix[W-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*W-1:W];
            F3_DIV, F3_DIVU:              fix_res = quo_fix;
            default:                      fix_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = (bus.i_start && idle_or_done) ||
                  (state_q == ST_CALC) || (state_q == ST_FIX);
        if (bus.i_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.i_start)
                        state_d = (special || is_fast) ? ST_DONE : ST_CALC;
                    else
                        state_d = ST_IDLE;
                end
                ST_CALC: if (cnt_q == NB_CNT'(W - 1)) state_d = ST_FIX;
                default: state_d = ST_DONE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            func3_q  <= '0;
            neg_q    <= 1'b0;
            rd_lat_q <= '0;
            result_q <= '0;
            rd_out_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state_d == ST_DONE);
            if (accept) begin
                cnt_q    <= '0;
                func3_q  <= f3;
                rd_lat_q <= bus.i_rd_addr;
                acc_q    <= {{W{1'b0}}, a_mag};
                opnd_q   <= b_mag;
                // Remainder follows the dividend; everything else the XOR.
                neg_q    <= (is_div && f3[1]) ? a_neg : (a_neg ^ b_neg);
                if (special) begin
                    result_q <= special_res;
                    rd_out_q <= bus.i_rd_addr;
                end
`ifdef MULDIV_FAST_MUL_EN
                else if (is_fast) begin
                    result_q <= fast_res;
                    rd_out_q <= bus.i_rd_addr;
                end
`endif
            end else if (state_q == ST_CALC) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q + 1'b1;
            end else if (state_q == ST_FIX && !bus.i_flush) begin
                result_q <= fix_res;
                rd_out_q <= rd_lat_q;
            end
        end
    end

    assign bus.o_busy    = busy;
    assign bus.o_done    = done_q;
    assign bus.o_result  = result_q;
    assign bus.o_rd_addr = rd_out_q;
endmodule
